// File: rtl/reaction_stim_ctrl.sv
// reaction_stim_ctrl: stimulus/measurement controller for the reaction timer.
// Waits a pseudo-random number of ms after start, lights the LED, then counts
// ms until the player's button edge. Results stay put until the next start.
module reaction_stim_ctrl #(
   parameter int unsigned CLK_PER_MS = 50000,
   parameter int unsigned MIN_DELAY  = 1000,
   parameter int unsigned RAND_BITS  = 11,
   parameter int unsigned MAX_MS     = 9999,
   parameter int unsigned TW         = 14
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          button,
   output logic          led,
   output logic [TW-1:0] time_ms,
   output logic          valid,
   output logic          too_early,
   output logic          timeout,
   output logic [2:0]    state_o
);

   localparam int unsigned PW         = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam int unsigned DW         = 16;
   localparam int unsigned LW         = 16;
   localparam logic [LW-1:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_WAIT  = 3'd1,
      S_STIM  = 3'd2,
      S_DONE  = 3'd3,
      S_EARLY = 3'd4,
      S_TOUT  = 3'd5
   } state_t;

   state_t          state;
   state_t          state_nx;
   logic [PW-1:0]   presc;
   logic [PW-1:0]   presc_nx;
   logic [DW-1:0]   delay_cnt;
   logic [DW-1:0]   delay_nx;
   logic [LW-1:0]   lfsr;
   logic [LW-1:0]   lfsr_nx;
   logic            btn_prev;

   logic            led_nx;
   logic [TW-1:0]   time_nx;
   logic            valid_nx;
   logic            too_early_nx;
   logic            timeout_nx;

   logic            press_c;
   logic            tick_c;
   logic            idle_like_c;
   logic            delay_last_c;
   logic            time_last_c;

   // Rising edge of the (already synchronized) button; a held button never counts.
   assign press_c      = button & ~btn_prev;
   // One ms tick on the last prescaler count.
   assign tick_c       = (presc == PW'(CLK_PER_MS - 1));
   assign delay_last_c = (delay_cnt == DW'(1));
   assign time_last_c  = (time_ms == TW'(MAX_MS - 1));
   // States in which start arms a new trial.
   assign idle_like_c  = (state == S_IDLE) || (state == S_DONE) ||
                         (state == S_EARLY) || (state == S_TOUT);

   // Fibonacci LFSR, taps 16,14,13,11, shifting right every clock.
   assign lfsr_nx = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[LW-1:1]};

   assign state_o = state;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         presc     <= '0;
         delay_cnt <= '0;
         lfsr      <= LFSR_SEED;
         btn_prev  <= 1'b0;
         led       <= 1'b0;
         time_ms   <= '0;
         valid     <= 1'b0;
         too_early <= 1'b0;
         timeout   <= 1'b0;
      end else begin
         state     <= state_nx;
         presc     <= presc_nx;
         delay_cnt <= delay_nx;
         lfsr      <= lfsr_nx;
         btn_prev  <= button;
         led       <= led_nx;
         time_ms   <= time_nx;
         valid     <= valid_nx;
         too_early <= too_early_nx;
         timeout   <= timeout_nx;
      end
   end

   // Next-state logic; a press always wins over a same-cycle tick.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE, S_EARLY, S_TOUT: begin
            if (start) state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (press_c)                     state_nx = S_EARLY;
            else if (tick_c && delay_last_c) state_nx = S_STIM;
         end
         S_STIM: begin
            if (press_c)                    state_nx = S_DONE;
            else if (tick_c && time_last_c) state_nx = S_TOUT;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Next values of the prescaler, delay counter and registered outputs.
   always_comb begin
      presc_nx     = tick_c ? '0 : PW'(presc + PW'(1));
      delay_nx     = delay_cnt;
      led_nx       = led;
      time_nx      = time_ms;
      valid_nx     = valid;
      too_early_nx = too_early;
      timeout_nx   = timeout;

      case (state)
         S_IDLE, S_DONE, S_EARLY, S_TOUT: begin
            if (start && idle_like_c) begin
               // Arm: pick the random delay and clear the previous result.
               presc_nx     = '0;
               delay_nx     = DW'(MIN_DELAY) + DW'(lfsr[RAND_BITS-1:0]);
               led_nx       = 1'b0;
               time_nx      = '0;
               valid_nx     = 1'b0;
               too_early_nx = 1'b0;
               timeout_nx   = 1'b0;
            end
         end
         S_WAIT: begin
            if (press_c) begin
               too_early_nx = 1'b1;
            end else if (tick_c) begin
               delay_nx = DW'(delay_cnt - DW'(1));
               if (delay_last_c) begin
                  // Stimulus on; restart the ms phase so the first count is a full ms.
                  presc_nx = '0;
                  led_nx   = 1'b1;
                  time_nx  = '0;
               end
            end
         end
         S_STIM: begin
            if (press_c) begin
               led_nx   = 1'b0;
               valid_nx = 1'b1;
            end else if (tick_c) begin
               if (time_last_c) begin
                  // Saturate at the limit instead of wrapping.
                  time_nx    = TW'(MAX_MS);
                  led_nx     = 1'b0;
                  timeout_nx = 1'b1;
               end else begin
                  time_nx = TW'(time_ms + TW'(1));
               end
            end
         end
         default: begin
            led_nx = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_reaction_stim_ctrl.sv
// Testbench for reaction_stim_ctrl: table of trials plus random trials, checked
// against an arithmetic model of trial outcome and LED timing.
module tb_reaction_stim_ctrl;

   localparam int CLK   = 4;
   localparam int MIN   = 5;
   localparam int RB    = 3;
   localparam int MAXMS = 20;
   localparam int TW    = 14;

   logic clk = 1'b0;
   logic reset;
   logic start;
   logic button;

   logic          led,   l_led;
   logic [TW-1:0] time_ms, l_time_ms;
   logic          valid, l_valid;
   logic          too_early, l_too_early;
   logic          timeout, l_timeout;
   logic [2:0]    state_o, l_state_o;

   int errors = 0;
   int checks = 0;

   logic [15:0] lf;
   logic [15:0] lf_edge;

   typedef struct {
      int off;     // <0: press that many cycles after start; >0: cycles after LED; 0: none
      bit hold;    // button held high across start and through the trial
      int st;
      int tm;
      int fl;      // {valid,too_early,timeout}
   } vec_t;

   vec_t tbl[11];

   always #5 clk = ~clk;

   reaction_stim_ctrl #(
      .CLK_PER_MS(CLK), .MIN_DELAY(MIN), .RAND_BITS(RB), .MAX_MS(MAXMS), .TW(TW)
   ) u_dut (
      .clk(clk), .reset(reset), .start(start), .button(button),
      .led(led), .time_ms(time_ms), .valid(valid), .too_early(too_early),
      .timeout(timeout), .state_o(state_o)
   );

   reaction_stim_ctrl #(
      .CLK_PER_MS(CLK), .MIN_DELAY(MIN), .RAND_BITS(RB), .MAX_MS(9999), .TW(TW)
   ) u_long (
      .clk(clk), .reset(reset), .start(start), .button(button),
      .led(l_led), .time_ms(l_time_ms), .valid(l_valid), .too_early(l_too_early),
      .timeout(l_timeout), .state_o(l_state_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
   endfunction

   // Advance one clock; the model LFSR follows, lf_edge is the value seen at that edge.
   task automatic clk1();
      @(posedge clk);
      lf_edge = lf;
      lf = reset ? 16'hACE1 : lfsr_step(lf);
      #1;
   endtask

   // Outcome of a trial from the rules: press timing versus the ms grid after the LED.
   task automatic expect_of(input int off, input bit hold, output int st, output int tm,
                            output int fl);
      int o;
      o = hold ? 0 : off;
      if (o < 0) begin
         st = 4; tm = 0; fl = 2;
      end else if (o == 0 || o > MAXMS * CLK) begin
         st = 5; tm = MAXMS; fl = 1;
      end else begin
         st = 3; tm = (o - 1) / CLK; fl = 4;
      end
   endtask

   task automatic run_trial(input string tag, input int off, input bit hold,
                            input int est, input int etm, input int efl);
      int d;
      int lim;
      int ends;
      logic seen;
      button = hold;
      start  = 1'b0;
      clk1();
      start = 1'b1;
      clk1();
      start = 1'b0;
      d = MIN + 32'(lf_edge[RB-1:0]);
      chk({tag, " arm state"}, 32'(state_o), 1);
      chk({tag, " arm flags"}, 32'({valid, too_early, timeout}), 0);
      chk({tag, " arm led"}, 32'(led), 0);
      if (off < 0) begin
         repeat (-off - 1) clk1();
         button = 1'b1;
         clk1();
      end else begin
         repeat (4 * d - 1) clk1();
         chk({tag, " led before"}, 32'(led), 0);
         clk1();
         chk({tag, " led rise"}, 32'(led), 1);
         chk({tag, " stim state"}, 32'(state_o), 2);
         chk({tag, " stim time"}, 32'(time_ms), 0);
         lim  = MAXMS * CLK;
         ends = (off > lim) ? off : lim;
         for (int c = 1; c <= ends; c++) begin
            button = hold || (off > 0 && c >= off);
            clk1();
            if (c == lim - 1 && (off == 0 || off >= lim))
               chk({tag, " last ms"}, 32'(time_ms), 32'(MAXMS - 1));
         end
      end
      chk({tag, " state"}, 32'(state_o), 32'(est));
      chk({tag, " time"}, 32'(time_ms), 32'(etm));
      chk({tag, " flags"}, 32'({valid, too_early, timeout}), 32'(efl));
      chk({tag, " led off"}, 32'(led), 0);
      if (off < 0) begin
         seen = 1'b0;
         for (int i = 0; i < 4 * d + 4; i++) begin
            clk1();
            seen = seen | led;
         end
         chk({tag, " led never"}, 32'(seen), 0);
      end
      button = 1'b0;
      repeat (3) clk1();
      chk({tag, " sticky state"}, 32'(state_o), 32'(est));
      chk({tag, " sticky time"}, 32'(time_ms), 32'(etm));
   endtask

   initial begin
      int st, tm, fl, k, off, d;

      tbl[0]  = '{-1,  1'b0, 4, 0,  2};
      tbl[1]  = '{-19, 1'b0, 4, 0,  2};
      tbl[2]  = '{1,   1'b0, 3, 0,  4};
      tbl[3]  = '{4,   1'b0, 3, 0,  4};
      tbl[4]  = '{5,   1'b0, 3, 1,  4};
      tbl[5]  = '{53,  1'b0, 3, 13, 4};
      tbl[6]  = '{79,  1'b0, 3, 19, 4};
      tbl[7]  = '{80,  1'b0, 3, 19, 4};
      tbl[8]  = '{0,   1'b0, 5, 20, 1};
      tbl[9]  = '{0,   1'b1, 5, 20, 1};
      tbl[10] = '{81,  1'b0, 5, 20, 1};

      lf      = 16'hACE1;
      lf_edge = 16'hACE1;
      reset   = 1'b1;
      start   = 1'b0;
      button  = 1'b0;
      repeat (3) clk1();
      chk("reset led", 32'(led), 0);
      chk("reset time", 32'(time_ms), 0);
      chk("reset flags", 32'({valid, too_early, timeout}), 0);
      chk("reset state", 32'(state_o), 0);
      reset = 1'b0;

      // 37 ms reaction on the long-limit instance; the short one times out at 20.
      run_trial("long", 37 * CLK + 1, 1'b0, 5, 20, 1);
      chk("long time", 32'(l_time_ms), 37);
      chk("long valid", 32'({l_valid, l_too_early, l_timeout}), 4);
      chk("long state", 32'(l_state_o), 3);
      chk("long led", 32'(l_led), 0);

      for (int i = 0; i < 11; i++)
         run_trial($sformatf("tbl%0d", i), tbl[i].off, tbl[i].hold, tbl[i].st, tbl[i].tm,
                   tbl[i].fl);

      for (int i = 0; i < 16; i++) begin
         k = 32'($urandom_range(0, 2));
         if (k == 0)      off = -32'($urandom_range(1, 19));
         else if (k == 1) off = 32'($urandom_range(1, 90));
         else             off = 0;
         expect_of(off, 1'b0, st, tm, fl);
         run_trial($sformatf("rnd%0d", i), off, 1'b0, st, tm, fl);
      end

      // Reset while the stimulus is lit.
      start = 1'b1;
      clk1();
      start = 1'b0;
      d = MIN + 32'(lf_edge[RB-1:0]);
      repeat (4 * d + 10) clk1();
      chk("mid led", 32'(led), 1);
      chk("mid time", 32'(time_ms), 2);
      reset = 1'b1;
      clk1();
      reset = 1'b0;
      chk("rst mid led", 32'(led), 0);
      chk("rst mid time", 32'(time_ms), 0);
      chk("rst mid flags", 32'({valid, too_early, timeout}), 0);
      chk("rst mid state", 32'(state_o), 0);
      clk1();
      chk("rst mid idle", 32'(state_o), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
